// File: rtl/qpu_exu_tragger.sv
// Consumer end of the exu event queue: drives the QPU timeline and queue trigger, buffers released
// events per channel for AWG/readout handshakes, and tracks per-qubit measurement history flags.
module qpu_exu_tragger #(
  parameter int TIME_W   = 16,
  parameter int QI_NUM   = 4,
  parameter int QI_EW    = 8,
  parameter int MS_NUM   = 1,
  parameter int MS_EW    = 4,
  parameter int HANG_CYC = 255,
  localparam int EV_NUM  = QI_NUM + MS_NUM,
  localparam int EV_W    = QI_NUM * QI_EW + MS_NUM * MS_EW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_start,
  input  logic              run_stop,
  output logic              o_tragger,
  output logic [TIME_W-1:0] tragger_o_clk,
  input  logic              tragger_i_clk_ena,
  input  logic [EV_NUM-1:0] evq_i_valid,
  input  logic [EV_W-1:0]   evq_i_data,
  output logic [EV_NUM-1:0] ch_o_vld,
  output logic [EV_W-1:0]   ch_o_data,
  input  logic [EV_NUM-1:0] ch_i_rdy,
  input  logic              meas_i_vld,
  input  logic [QI_NUM-1:0] meas_i_qubit,
  input  logic              meas_i_bit,
  output logic [QI_NUM-1:0] qubit_measure_zero,
  output logic [QI_NUM-1:0] qubit_measure_one,
  output logic [QI_NUM-1:0] qubit_measure_equ,
  output logic              run_done,
  output logic              ch_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_DONE} state_t;

  localparam int HANG_W = $clog2(HANG_CYC + 1);
  localparam logic [HANG_W-1:0] HANG_MAX  = HANG_W'(HANG_CYC);
  localparam logic [HANG_W-1:0] HANG_LAST = HANG_W'(HANG_CYC - 1);

  state_t              state, state_nxt;
  logic [TIME_W-1:0]   timeline;
  logic [HANG_W-1:0]   hang_cnt;
  logic [EV_NUM-1:0]   busy, load;
  logic [EV_W-1:0]     load_bits;
  logic                in_run, stall_req, hang_hit, start_clr, overrun_hit;
  logic [QI_NUM-1:0]   meas_cur, meas_prv, cur_vld, prv_vld;

  assign in_run      = (state == S_RUN);
  assign busy        = ch_o_vld & ~ch_i_rdy;
  assign stall_req   = |busy;
  assign load        = in_run ? (evq_i_valid & ~busy) : '0;
  assign overrun_hit = in_run & (|(evq_i_valid & busy));
  // The cycle that would bring the starvation count to HANG_CYC ends the run.
  assign hang_hit    = ~tragger_i_clk_ena & (hang_cnt >= HANG_LAST);
  assign start_clr   = run_start & ~run_stop & ((state == S_IDLE) | (state == S_DONE));

  assign o_tragger     = in_run;
  assign tragger_o_clk = timeline;

  for (genvar k = 0; k < QI_NUM; k++) begin : g_qi_mask
    assign load_bits[k*QI_EW +: QI_EW] = {QI_EW{load[k]}};
  end
  for (genvar m = 0; m < MS_NUM; m++) begin : g_ms_mask
    assign load_bits[QI_NUM*QI_EW + m*MS_EW +: MS_EW] = {MS_EW{load[QI_NUM+m]}};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run_start) state_nxt = S_RUN;
      S_RUN: begin
        if (stall_req)     state_nxt = S_STALL;
        else if (hang_hit) state_nxt = S_DONE;
      end
      S_STALL: if (!stall_req) state_nxt = S_RUN;
      S_DONE:  if (run_start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
    if (run_stop) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      timeline   <= '0;
      hang_cnt   <= '0;
      run_done   <= 1'b0;
      ch_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_clr) begin
        timeline   <= '0;
        hang_cnt   <= '0;
        run_done   <= 1'b0;
        ch_overrun <= 1'b0;
      end else begin
        if (in_run) begin
          if (tragger_i_clk_ena) begin
            timeline <= timeline + TIME_W'(1);
            hang_cnt <= '0;
          end else if (hang_cnt != HANG_MAX) begin
            hang_cnt <= hang_cnt + HANG_W'(1);
          end
        end
        if (in_run && (state_nxt == S_DONE)) run_done <= 1'b1;
        if (overrun_hit) ch_overrun <= 1'b1;
      end
    end
  end

  // Channel registers: a held event blocks reload; accept and reload may share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_o_vld  <= '0;
      ch_o_data <= '0;
    end else begin
      ch_o_vld  <= run_stop ? '0 : (load | busy);
      ch_o_data <= (ch_o_data & ~load_bits) | (evq_i_data & load_bits);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_cur <= '0;
      meas_prv <= '0;
      cur_vld  <= '0;
      prv_vld  <= '0;
    end else if (start_clr) begin
      meas_cur <= '0;
      meas_prv <= '0;
      cur_vld  <= '0;
      prv_vld  <= '0;
    end else if (meas_i_vld) begin
      meas_prv <= (meas_prv & ~meas_i_qubit) | (meas_cur & meas_i_qubit);
      prv_vld  <= (prv_vld & ~meas_i_qubit) | (cur_vld & meas_i_qubit);
      meas_cur <= (meas_cur & ~meas_i_qubit) | ({QI_NUM{meas_i_bit}} & meas_i_qubit);
      cur_vld  <= cur_vld | meas_i_qubit;
    end
  end

  assign qubit_measure_zero = cur_vld & ~meas_cur;
  assign qubit_measure_one  = cur_vld & meas_cur;
  assign qubit_measure_equ  = prv_vld & cur_vld & ~(meas_prv ^ meas_cur);

endmodule

// File: tb/tb_qpu_exu_tragger.sv
// Scoreboard bench for qpu_exu_tragger: a procedural reference model tracks run state, timeline,
// pending channel events and qubit history; a negedge monitor matches delivered channel events.
`timescale 1ns/1ps
module tb_qpu_exu_tragger;
  localparam int TIME_W = 16, QI_NUM = 4, QI_EW = 8, MS_NUM = 1, MS_EW = 4, HANG_CYC = 255;
  localparam int EV_NUM = QI_NUM + MS_NUM;
  localparam int EV_W   = QI_NUM * QI_EW + MS_NUM * MS_EW;
  localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_DONE = 3;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              run_start, run_stop, o_tragger, tragger_i_clk_ena;
  logic [TIME_W-1:0] tragger_o_clk;
  logic [EV_NUM-1:0] evq_i_valid, ch_o_vld, ch_i_rdy;
  logic [EV_W-1:0]   evq_i_data, ch_o_data;
  logic              meas_i_vld, meas_i_bit, run_done, ch_overrun;
  logic [QI_NUM-1:0] meas_i_qubit, qubit_measure_zero, qubit_measure_one, qubit_measure_equ;

  always #5 clk = ~clk;

  qpu_exu_tragger #(.TIME_W(TIME_W), .QI_NUM(QI_NUM), .QI_EW(QI_EW), .MS_NUM(MS_NUM),
                    .MS_EW(MS_EW), .HANG_CYC(HANG_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .run_start(run_start), .run_stop(run_stop),
    .o_tragger(o_tragger), .tragger_o_clk(tragger_o_clk), .tragger_i_clk_ena(tragger_i_clk_ena),
    .evq_i_valid(evq_i_valid), .evq_i_data(evq_i_data), .ch_o_vld(ch_o_vld),
    .ch_o_data(ch_o_data), .ch_i_rdy(ch_i_rdy), .meas_i_vld(meas_i_vld),
    .meas_i_qubit(meas_i_qubit), .meas_i_bit(meas_i_bit),
    .qubit_measure_zero(qubit_measure_zero), .qubit_measure_one(qubit_measure_one),
    .qubit_measure_equ(qubit_measure_equ), .run_done(run_done), .ch_overrun(ch_overrun)
  );

  typedef struct { int ch; logic [7:0] data; } exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0;
  bit quiet = 1'b0;

  // Reference model state
  int          m_state = M_IDLE;
  logic [15:0] m_time = '0;
  int          m_starve = 0;
  bit          m_done = 1'b0, m_ovr = 1'b0;
  bit [4:0]    m_pend = '0;
  bit [3:0]    m_cur = '0, m_prv = '0, m_cv = '0, m_pv = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] field(logic [EV_W-1:0] d, int k);
    if (k < QI_NUM) return d[k*QI_EW +: QI_EW];
    return {4'b0, d[QI_NUM*QI_EW + (k-QI_NUM)*MS_EW +: MS_EW]};
  endfunction

  task automatic check_all();
    chk("ch_o_vld", ch_o_vld, m_pend);
    chk("o_tragger", o_tragger, m_state == M_RUN);
    chk("tragger_o_clk", tragger_o_clk, m_time);
    chk("run_done", run_done, m_done);
    chk("ch_overrun", ch_overrun, m_ovr);
    chk("meas_zero", qubit_measure_zero, m_cv & ~m_cur);
    chk("meas_one", qubit_measure_one, m_cv & m_cur);
    chk("meas_equ", qubit_measure_equ, m_pv & m_cv & ~(m_prv ^ m_cur));
  endtask

  // Apply the currently driven inputs to the model, advance one clock, then compare.
  task automatic tick();
    bit [4:0] occ;
    bit start;
    occ   = m_pend & ~ch_i_rdy;
    start = run_start && !run_stop && (m_state == M_IDLE || m_state == M_DONE);
    if (run_stop) begin
      m_state = M_IDLE;
      m_pend  = '0;
      sb.delete();
    end else begin
      case (m_state)
        M_RUN: begin
          for (int k = 0; k < EV_NUM; k++)
            if (evq_i_valid[k]) begin
              if (occ[k]) m_ovr = 1'b1;
              else sb.push_back('{ch: k, data: field(evq_i_data, k)});
            end
          m_pend = occ | evq_i_valid;
          if (tragger_i_clk_ena) begin m_time++; m_starve = 0; end
          else m_starve++;
          if (|occ) m_state = M_STALL;
          else if (m_starve >= HANG_CYC) begin m_state = M_DONE; m_done = 1'b1; end
        end
        M_STALL: begin m_pend = occ; if (!(|occ)) m_state = M_RUN; end
        M_DONE:  begin m_pend = occ; if (start) m_state = M_RUN; end
        default: if (start) m_state = M_RUN;
      endcase
    end
    if (start) begin
      m_time = '0; m_starve = 0; m_done = 1'b0; m_ovr = 1'b0;
      m_cur = '0; m_prv = '0; m_cv = '0; m_pv = '0;
    end else if (meas_i_vld) begin
      for (int i = 0; i < QI_NUM; i++)
        if (meas_i_qubit[i]) begin
          m_prv[i] = m_cur[i]; m_pv[i] = m_cv[i]; m_cur[i] = meas_i_bit; m_cv[i] = 1'b1;
        end
    end
    @(posedge clk);
    #1;
    if (!quiet) check_all();
  endtask

  // Monitor: every accepted channel event must match the oldest expected event for that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < EV_NUM; k++)
        if (ch_o_vld[k] && ch_i_rdy[k]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < sb.size(); j++)
            if (sb[j].ch == k) begin idx = j; break; end
          if (idx < 0) begin
            checks++; errors++;
            $display("FAIL ch%0d_unexpected: got data %0h expected no event", k, field(ch_o_data, k));
          end else begin
            chk($sformatf("ch%0d_data", k), field(ch_o_data, k), sb[idx].data);
            sb.delete(idx);
          end
        end
    end
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int guard;
    logic [15:0] t_done;
    run_start = 0; run_stop = 0; tragger_i_clk_ena = 0;
    evq_i_valid = '0; evq_i_data = '0; ch_i_rdy = '1;
    meas_i_vld = 0; meas_i_qubit = '0; meas_i_bit = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // start and count five enabled cycles
    run_start = 1; tick(); run_start = 0;
    tragger_i_clk_ena = 1;
    repeat (5) tick();
    chk("tl_after5", tragger_o_clk, 16'd5);
    chk("trig_run", o_tragger, 1'b1);
    chk("vld_none", ch_o_vld, 5'd0);

    // channel 0 held by a stalled consumer, plus an overrun attempt
    ch_i_rdy = 5'b11110; evq_i_valid = 5'b00001; evq_i_data = 36'hA5;
    tick();
    chk("ch0_vld", ch_o_vld[0], 1'b1);
    chk("trig_before_stall", o_tragger, 1'b1);
    evq_i_data = 36'h5A;
    tick();
    evq_i_valid = '0;
    tick(); tick();
    chk("stall_trig", o_tragger, 1'b0);
    chk("stall_freeze", tragger_o_clk, 16'd7);
    chk("overrun", ch_overrun, 1'b1);
    ch_i_rdy = '1;
    tick();
    chk("resume_trig", o_tragger, 1'b1);
    chk("resume_vld", ch_o_vld, 5'd0);
    tick();
    chk("resume_time", tragger_o_clk, 16'd8);

    // qubit 2 history: 1, 1, then 0
    meas_i_vld = 1; meas_i_qubit = 4'b0100; meas_i_bit = 1;
    tick(); tick();
    chk("q2_one", qubit_measure_one[2], 1'b1);
    chk("q2_equ", qubit_measure_equ[2], 1'b1);
    meas_i_bit = 0;
    tick();
    chk("q2_zero", qubit_measure_zero[2], 1'b1);
    chk("q2_equ0", qubit_measure_equ[2], 1'b0);
    chk("q2_one0", qubit_measure_one[2], 1'b0);
    meas_i_vld = 0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      evq_i_valid = 5'($urandom);
      evq_i_data  = {4'($urandom), 32'($urandom)};
      ch_i_rdy    = 5'($urandom | $urandom);
      tragger_i_clk_ena = ($urandom_range(0, 9) != 0);
      meas_i_vld   = ($urandom_range(0, 2) == 0);
      meas_i_qubit = 4'($urandom);
      meas_i_bit   = 1'($urandom);
      tick();
    end
    evq_i_valid = '0; meas_i_vld = 0; ch_i_rdy = '1; tragger_i_clk_ena = 1;
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);

    // timeline wrap
    quiet = 1'b1;
    guard = 0;
    while (m_time != 16'hFFFF && guard < 70000) begin tick(); guard++; end
    quiet = 1'b0;
    chk("tl_max", tragger_o_clk, 16'hFFFF);
    tick();
    chk("tl_wrap", tragger_o_clk, 16'h0000);
    chk("wrap_no_done", run_done, 1'b0);

    // starvation: 254 cycles still running, 255th ends the run
    tragger_i_clk_ena = 0;
    repeat (254) tick();
    chk("hang254_done", run_done, 1'b0);
    chk("hang254_trig", o_tragger, 1'b1);
    tick();
    chk("hang_done", run_done, 1'b1);
    chk("hang_trig", o_tragger, 1'b0);
    t_done = m_time;
    tick();
    chk("done_freeze", tragger_o_clk, t_done);
    run_start = 1; tick(); run_start = 0;
    chk("restart_done", run_done, 1'b0);
    chk("restart_time", tragger_o_clk, 16'd0);
    chk("restart_trig", o_tragger, 1'b1);

    // stop while stalled with a pending measure-channel event
    tragger_i_clk_ena = 1;
    ch_i_rdy = 5'b01111; evq_i_valid = 5'b10000; evq_i_data = 36'h7_0000_0000;
    tick();
    evq_i_valid = '0;
    tick();
    chk("pre_stop_trig", o_tragger, 1'b0);
    chk("pre_stop_vld4", ch_o_vld[4], 1'b1);
    run_stop = 1; tick(); run_stop = 0;
    chk("stop_vld", ch_o_vld, 5'd0);
    chk("stop_trig", o_tragger, 1'b0);
    evq_i_valid = '1; evq_i_data = {4'($urandom), 32'($urandom)};
    repeat (3) tick();
    chk("idle_ignore", ch_o_vld, 5'd0);
    evq_i_valid = '0;

    // simultaneous start and stop stays idle
    run_start = 1; run_stop = 1; tick(); run_start = 0; run_stop = 0;
    chk("start_stop_trig", o_tragger, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
